// File: rtl/fir_pkg.sv
// Shared widths, FSM encoding and the round/saturate step for the stereo FIR stage.
package fir_pkg;

  localparam int DATA_WIDTH = 20;
  localparam int COEF_WIDTH = 18;
  localparam int COEF_FRAC  = 16;
  localparam int TAPS       = 16;
  localparam int TAP_AW     = 4;
  localparam int ACC_WIDTH  = DATA_WIDTH + COEF_WIDTH + TAP_AW;
  localparam int PROD_WIDTH = DATA_WIDTH + COEF_WIDTH;
  localparam int SEQ_WIDTH  = 11;

  localparam logic [SEQ_WIDTH-1:0]  CAPTURE_SEQ = 11'h010;
  localparam logic [COEF_WIDTH-1:0] COEF_ONE    = 18'h10000;
  localparam logic [DATA_WIDTH-1:0] SAT_MAX     = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] SAT_MIN     = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    MAC_L = 3'd2,
    MAC_R = 3'd3,
    OUT   = 3'd4
  } state_e;

  // Round half up at the Q.16 point, then clamp to the signed sample range.
  function automatic logic [DATA_WIDTH-1:0] round_sat(input logic signed [ACC_WIDTH-1:0] acc);
    logic signed [ACC_WIDTH-1:0] half;
    logic signed [ACC_WIDTH-1:0] sum;
    logic signed [ACC_WIDTH-1:0] shr;
    logic signed [ACC_WIDTH-1:0] max_v;
    logic signed [ACC_WIDTH-1:0] min_v;
    half  = $signed({{(ACC_WIDTH-COEF_FRAC){1'b0}}, 1'b1, {(COEF_FRAC-1){1'b0}}});
    sum   = acc + half;
    shr   = sum >>> COEF_FRAC;
    max_v = $signed({{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}});
    min_v = $signed({{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}});
    if (shr > max_v)      round_sat = SAT_MAX;
    else if (shr < min_v) round_sat = SAT_MIN;
    else                  round_sat = shr[DATA_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// Coefficient register file shared by both channels; resets to an identity filter.
module fir_coef_bank
  import fir_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  busy_i,
  input  logic                  we_i,
  input  logic [TAP_AW-1:0]     waddr_i,
  input  logic [COEF_WIDTH-1:0] wdata_i,
  input  logic [TAP_AW-1:0]     raddr_i,
  output logic [COEF_WIDTH-1:0] rdata_o,
  output logic                  rej_o
);

  logic [COEF_WIDTH-1:0] coef_q [TAPS];
  logic                  rej_q;

  // Writes during a pass are dropped so a pass always sees one coefficient set.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < TAPS; i++) coef_q[i] <= (i == 0) ? COEF_ONE : '0;
      rej_q <= 1'b0;
    end else begin
      if (we_i && !busy_i) coef_q[waddr_i] <= wdata_i;
      rej_q <= we_i & busy_i;
    end
  end

  assign rdata_o = coef_q[raddr_i];
  assign rej_o   = rej_q;

endmodule

// File: rtl/fir_mac_filter.sv
// Stereo 16-tap FIR: one time-multiplexed MAC pass per channel per codec frame.
module fir_mac_filter
  import fir_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic [SEQ_WIDTH-1:0]  seq,
  input  logic [DATA_WIDTH-1:0] l_in,
  input  logic [DATA_WIDTH-1:0] r_in,
  output logic [DATA_WIDTH-1:0] l_out,
  output logic [DATA_WIDTH-1:0] r_out,
  output logic                  out_valid,
  output logic                  busy,
  output logic                  overrun,
  input  logic                  coef_we,
  input  logic [TAP_AW-1:0]     coef_addr,
  input  logic [COEF_WIDTH-1:0] coef_data,
  output logic                  coef_rej,
  output logic [2:0]            state_dbg
);

  state_e                       state_q, state_d;
  logic                         hit_q;
  logic [TAP_AW-1:0]            idx_q, idx_d;
  logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic signed [DATA_WIDTH-1:0] x_l_q [TAPS];
  logic signed [DATA_WIDTH-1:0] x_l_d [TAPS];
  logic signed [DATA_WIDTH-1:0] x_r_q [TAPS];
  logic signed [DATA_WIDTH-1:0] x_r_d [TAPS];
  logic [DATA_WIDTH-1:0]        l_hold_q, l_hold_d;
  logic [DATA_WIDTH-1:0]        l_out_q, l_out_d;
  logic [DATA_WIDTH-1:0]        r_out_q, r_out_d;
  logic                         valid_q, valid_d;
  logic                         overrun_q, overrun_d;

  logic                         hit, trigger, last_tap;
  logic signed [COEF_WIDTH-1:0] coef_rd;
  logic signed [DATA_WIDTH-1:0] x_sel;
  logic signed [PROD_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0]  acc_sum;

  fir_coef_bank u_coef (
    .clk_i   (clock),
    .rst_ni  (reset),
    .busy_i  (busy),
    .we_i    (coef_we),
    .waddr_i (coef_addr),
    .wdata_i (coef_data),
    .raddr_i (idx_q),
    .rdata_o (coef_rd),
    .rej_o   (coef_rej)
  );

  // hit_q resets high so a seq already parked on the capture value does not fire.
  assign hit      = (seq == CAPTURE_SEQ);
  assign trigger  = hit & ~hit_q;
  assign last_tap = (idx_q == TAP_AW'(TAPS - 1));

  assign x_sel   = (state_q == MAC_R) ? x_r_q[idx_q] : x_l_q[idx_q];
  assign prod    = x_sel * coef_rd;
  assign acc_sum = acc_q + {{(ACC_WIDTH-PROD_WIDTH){prod[PROD_WIDTH-1]}}, prod};

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    acc_d     = acc_q;
    x_l_d     = x_l_q;
    x_r_d     = x_r_q;
    l_hold_d  = l_hold_q;
    l_out_d   = l_out_q;
    r_out_d   = r_out_q;
    valid_d   = 1'b0;
    overrun_d = overrun_q | (trigger & (state_q != IDLE));
    case (state_q)
      IDLE: if (trigger) state_d = LOAD;
      LOAD: begin
        for (int k = 1; k < TAPS; k++) begin
          x_l_d[k] = x_l_q[k-1];
          x_r_d[k] = x_r_q[k-1];
        end
        x_l_d[0] = l_in;
        x_r_d[0] = r_in;
        acc_d    = '0;
        idx_d    = '0;
        state_d  = MAC_L;
      end
      MAC_L: begin
        acc_d = acc_sum;
        idx_d = idx_q + TAP_AW'(1);
        if (last_tap) begin
          l_hold_d = round_sat(acc_sum);
          acc_d    = '0;
          idx_d    = '0;
          state_d  = MAC_R;
        end
      end
      MAC_R: begin
        // The right sum stays in acc and is rounded while leaving OUT.
        acc_d = acc_sum;
        idx_d = idx_q + TAP_AW'(1);
        if (last_tap) state_d = OUT;
      end
      OUT: begin
        l_out_d = l_hold_q;
        r_out_d = round_sat(acc_q);
        valid_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      hit_q     <= 1'b1;
      idx_q     <= '0;
      acc_q     <= '0;
      for (int k = 0; k < TAPS; k++) begin
        x_l_q[k] <= '0;
        x_r_q[k] <= '0;
      end
      l_hold_q  <= '0;
      l_out_q   <= '0;
      r_out_q   <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hit_q     <= hit;
      idx_q     <= idx_d;
      acc_q     <= acc_d;
      x_l_q     <= x_l_d;
      x_r_q     <= x_r_d;
      l_hold_q  <= l_hold_d;
      l_out_q   <= l_out_d;
      r_out_q   <= r_out_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  // Output contract: l_out/r_out change only on the edge that raises out_valid
  // for one cycle; busy spans trigger edge up to (not including) that cycle.
  assign l_out     = l_out_q;
  assign r_out     = r_out_q;
  assign out_valid = valid_q;
  assign busy      = (state_q != IDLE);
  assign overrun   = overrun_q;
  assign state_dbg = state_q;

endmodule

// File: doc/fir_mac_filter.md
Name: fir_mac_filter

Overview:
- Stereo FIR filter stage between the codec serial interface's receive outputs and its transmit inputs.
- Consumes the parallel 20-bit left/right samples recovered from the codec and the shared frame sequence counter `seq`.
- Runs one time-multiplexed multiply-accumulate pass per channel per audio frame.
- Presents filtered samples back for transmission well before the interface's `seq` > 0x1D8 reload window.

Parameters:
- DATA_WIDTH, 20, signed sample width in and out.
- COEF_WIDTH, 18, signed coefficient width, Q2.16.
- COEF_FRAC, 16, coefficient fraction bits.
- TAPS, 16, filter length per channel; coefficients are shared by both channels.
- TAP_AW, 4, coefficient address width (log2 TAPS).
- ACC_WIDTH, 42, accumulator width (DATA_WIDTH+COEF_WIDTH+TAP_AW).
- SEQ_WIDTH, 11, width of `seq`.
- CAPTURE_SEQ, 11'h010, `seq` value that triggers a frame.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- seq  in  SEQ_WIDTH  frame sequence count.
- l_in  in  DATA_WIDTH  left sample from codec interface.
- r_in  in  DATA_WIDTH  right sample from codec interface.
- l_out  out  DATA_WIDTH  filtered left sample, to codec interface.
- r_out  out  DATA_WIDTH  filtered right sample, to codec interface.
- out_valid  out  1  one-cycle pulse when l_out/r_out update.
- busy  out  1  high from the trigger edge until the cycle out_valid is high.
- overrun  out  1  sticky; a trigger arrived while busy.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  TAP_AW  tap index.
- coef_data  in  COEF_WIDTH  coefficient value.
- coef_rej  out  1  one-cycle pulse; a write was dropped because busy was high.

Behaviour:
- Reset (async assert, sync release) sets:
  - state IDLE; delay lines all 0; l_out = r_out = 0.
  - out_valid, busy, overrun, coef_rej = 0.
  - coef[0] = 18'h10000 (1.0), all other coefficients 0, i.e. identity filter.
  - hit_d = 1.
- Trigger detection:
  - hit = (seq == CAPTURE_SEQ); hit_d registers hit.
  - trigger = hit & ~hit_d, so there is no trigger if seq already equals CAPTURE_SEQ at reset release.
- State machine:
  - IDLE: on trigger go to LOAD and set busy.
  - LOAD (1 cycle): shift l_in into x_l[0], x_r likewise (x[k] <= x[k-1]); clear accumulator; idx = 0; go to MAC_L.
  - MAC_L (TAPS cycles): acc += x_l[idx]*coef[idx] (full signed product, sign-extended to ACC_WIDTH); idx++. On the last tap, latch the rounded/saturated L result, clear acc, idx = 0, go to MAC_R.
  - MAC_R (TAPS cycles): same computation on x_r; on the last tap go to OUT.
  - OUT (1 cycle): register l_out and r_out together; out_valid = 1; busy = 0; go to IDLE.
- Latency: outputs and out_valid change exactly 2*TAPS+2 rising edges after the trigger edge (34 at defaults). out_valid is high for exactly 1 cycle.
- Result formation:
  - y = (acc + 2^(COEF_FRAC-1)) >>> COEF_FRAC (round half up).
  - Saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- Trigger while state != IDLE: ignored, overrun = 1 (cleared only by reset). The current pass completes unaltered.
- Coefficient writes:
  - coef_we with busy = 0: coef[coef_addr] <= coef_data on that edge, visible to the next pass.
  - coef_we with busy = 1: write dropped, coef_rej pulses the next cycle.
- l_in/r_in are sampled only in LOAD; the inputs are otherwise don't-care.
- Reset asserted mid-pass: everything returns to reset values immediately, including coefficients. No out_valid is produced.

Decomposition:
- Package fir_pkg holds:
  - DATA_WIDTH, COEF_WIDTH, COEF_FRAC, TAPS, ACC_WIDTH.
  - State encoding constants IDLE, LOAD, MAC_L, MAC_R, OUT.
  - The round-and-saturate function.
- One sub-module, fir_coef_bank: a TAPS x COEF_WIDTH register file with the identity reset, a write port gated by ~busy, and a combinational read by idx.
- Delay lines, MAC datapath and FSM stay in fir_mac_filter.

Test Plan:
- Identity after reset: l_in = 20'h12345, r_in = 20'hF0000, seq steps through 11'h010. Required: l_out = 20'h12345, r_out = 20'hF0000, out_valid high for one cycle exactly 34 clocks after the trigger edge, busy low that same cycle.
- Impulse response: write coef[k] = k*18'h1000, then drive l_in = 20'h10000 for one frame and 0 for 16 frames. Required: l_out sequence 0, 20'h01000, 20'h02000, ..., 20'h0F000, then 0.
- Saturation: all coef = 18'h10000, l_in held at 20'h7FFFF for 16 frames gives l_out = 20'h7FFFF; held at 20'h80000 gives 20'h80000.
- Rounding: coef[0] = 18'h08000, others 0. l_in = 20'h00003 gives l_out = 20'h00002; l_in = 20'hFFFFD gives 20'hFFFFF.
- Overrun and write rejection: re-enter seq = 11'h010 during MAC_L, and pulse coef_we during MAC_R. Required: overrun = 1 and stays set; coef_rej pulses once; the output matches a single clean pass; the coefficient is unchanged.
- Reset mid-pass: drop reset 10 cycles after the trigger. Required: l_out/r_out = 0, busy = 0, no out_valid, and the next frame reproduces the identity result.
